// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, arbiter
// state encoding and a helper that identifies sizes the memory can store.
package data_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // Unsigned sizes only make sense for loads; anything else writes nothing.
    function automatic logic is_store_size(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin chooser: a lone requester wins outright, a tie
// goes to the requester that did not win most recently.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       pick_o
);

    always_comb begin
        valid_o = |req_i;
        pick_o  = 1'b0;
        case (req_i)
            2'b01:   pick_o = 1'b0;
            2'b10:   pick_o = 1'b1;
            2'b11:   pick_o = ~last_grant_i;
            default: pick_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store unit (port 0) and the DMA/debug loader (port 1).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [2:0]            m0_size,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [2:0]            m1_size,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pick_valid, pick_port;
    logic                  gnt0, gnt1;
    logic                  m0_rvalid_q, m1_rvalid_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // The port served this cycle already counts as the latest winner when the
    // next grant is chosen, so a tie at the end of GNTn goes to the other port.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    rr_pick2 u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_d),
        .valid_o      (pick_valid),
        .pick_o       (pick_port)
    );

    always_comb begin
        state_d = IDLE;
        if (pick_valid) begin
            state_d = pick_port ? GNT1 : GNT0;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        mem_we    = 1'b0;
        mem_size  = SZ_W;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            GNT0: begin
                mem_we    = m0_we && is_store_size(m0_size);
                mem_size  = m0_size;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
            end
            GNT1: begin
                mem_we    = m1_we && is_store_size(m1_size);
                mem_size  = m1_size;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the values from before this edge, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m0_rvalid_q  <= gnt0 && !m0_we;
            m1_rvalid_q  <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) begin
                m0_rdata_q <= mem_rdata;
            end
            if (gnt1 && !m1_we) begin
                m1_rdata_q <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port byte-addressable data memory between two requesters: port 0 is the core load/store unit and port 1 is the DMA/debug loader.
- Uses a req/gnt handshake with round-robin arbitration.
- Drives the memory's size, address, write-data and write-enable inputs.
- Returns registered read data with an rvalid strobe.
- Sits between the requesters and the data memory; the memory is unchanged.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 17, byte-address width (matches data memory)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
m0_req  in  1  port 0 access request; held with its fields stable until m0_gnt
m0_we  in  1  port 0 write (1) / read (0)
m0_size  in  3  port 0 size code (000 b, 001 h, 010 w, 100 bu, 101 hu)
m0_addr  in  ADDR_WIDTH  port 0 byte address
m0_wdata  in  DATA_WIDTH  port 0 store data
m0_gnt  out  1  one-cycle pulse: port 0 access performed this cycle
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid (reads only)
m0_rdata  out  DATA_WIDTH  port 0 load result, registered
m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
mem_size  out  3  to memory size control
mem_addr  out  ADDR_WIDTH  to memory address
mem_wdata  out  DATA_WIDTH  to memory write data
mem_we  out  1  to memory write enable
mem_rdata  in  DATA_WIDTH  combinational read data from memory

Behaviour:
- Reset is asynchronous and active-high on rst. On assertion, regardless of state or an in-flight access:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - all gnt and rvalid = 0; all rdata = 0.
  - mem_we = 0 immediately.
- FSM states: IDLE, GNT0, GNT1 (registered).
  - From IDLE: no req -> IDLE. Only mX_req -> GNTX. Both -> GNT of the port != last_grant.
  - From GNTn: last_grant <= n. Next state is chosen as from IDLE, using current reqs and the updated last_grant. The other port wins ties.
- Back-to-back alternating accesses sustain one access per cycle. A single port re-requesting with no contention is also granted every cycle.
- In GNTn:
  - mem_addr, mem_size and mem_wdata are driven combinationally from port n; mn_gnt = 1.
  - mem_we = mn_we AND (mn_size in {000,001,010}). Illegal store sizes are granted but write nothing.
- In IDLE, memory outputs are mem_we = 0, mem_addr = 0, mem_size = 010, mem_wdata = 0.
- Read path: in GNTn with mn_we = 0, mem_rdata is captured into mn_rdata at the clock edge, and mn_rvalid = 1 for the following cycle.
  - mn_rdata holds its value until the next read on that port.
  - Writes produce no rvalid.
- Latency: req rises in cycle N while IDLE -> gnt in N+1 -> rvalid in N+2.
  - If the FSM is already granting the other port, gnt is delayed by one cycle per competing grant.
- Requester rule: mX_req may drop only in the cycle after mX_gnt. A req that is still high in the gnt cycle is treated as a new request.
- Read-after-write across ports: a write in cycle K commits at the K edge, so a read granted in K+1 returns the new data.
- The arbiter does not check address range or alignment; it passes addresses through unchanged.
- gnt is never asserted on both ports in the same cycle; the FSM states are mutually exclusive.

Decomposition:
- Package data_mem_pkg:
  - size constants SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101
  - state enum arb_state_e {IDLE, GNT0, GNT1}
  - function is_store_size()
- Sub-module rr_pick2: combinational round-robin chooser. Inputs req[1:0] and last_grant; outputs valid and pick.

Test Plan:
- Reset mid-access: assert rst while in GNT1 with m1_we=1 -> mem_we=0 in the same cycle, state IDLE, all gnt/rvalid/rdata=0. After release, both req high -> m0_gnt first.
- Single write then read: m0 sw addr 0x100 data 0xDEADBEEF, then lw 0x100 -> m0_gnt in cycles N+1 and N+2; m0_rvalid in N+3 with m0_rdata=0xDEADBEEF.
- Contention: both req continuously, m0 lw 0x10, m1 lw 0x20 -> gnt alternates 0,1,0,1 every cycle and each rvalid follows its gnt by 1 cycle.
- Cross-port RAW: m1 sb 0x40 data 0x80, immediately followed by m0 lb 0x40 -> m0_rdata=0xFFFFFF80. A subsequent m0 lbu 0x40 -> 0x00000080.
- Illegal store size: m0_we=1, m0_size=3'b111, addr 0x8 -> m0_gnt pulses, mem_we stays 0, memory at 0x8 unchanged (a later lw compares to the preload).
- Idle behaviour: no requests for 10 cycles -> mem_we=0, mem_size=010, no gnt/rvalid. A lone m1 req -> m1_gnt exactly 1 cycle later.
